// File: rtl/countdown_timer.sv
// Loadable down-counting timer with a clock prescaler, pause and auto-reload.
// A start/busy/done handshake brackets each timed interval; tick marks every decrement.
module countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             pause_i,
  input  logic             auto_reload_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             tick_o,
  output logic             done_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [PW-1:0]    psc_q;
  logic             busy_q;
  logic             tick_q;
  logic             done_q;

  logic [WIDTH-1:0] count_dec_d;
  logic [PW-1:0]    psc_inc_d;
  logic             dec_edge_d;
  logic             terminal_d;

  // Arithmetic helpers for the counting step.
  always_comb begin
    count_dec_d = count_q - WIDTH'(1);
    psc_inc_d   = psc_q + PW'(1);
    dec_edge_d  = (psc_q == PSC_LAST);
    terminal_d  = (count_q == WIDTH'(1));
  end

  // Timer FSM with registered count, busy and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      psc_q    <= '0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (start_i) begin
        psc_q <= '0;
        if (load_val_i != '0) begin
          count_q  <= load_val_i;
          reload_q <= load_val_i;
          state_q  <= pause_i ? HOLD : RUN;
          busy_q   <= 1'b1;
        end else begin
          count_q <= '0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          RUN, HOLD: begin
            if (pause_i) begin
              state_q <= HOLD;
            end else begin
              // Leaving HOLD resumes counting on that same edge.
              state_q <= RUN;
              if (!dec_edge_d) begin
                psc_q <= psc_inc_d;
              end else begin
                psc_q <= '0;
                if (count_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end else begin
                  tick_q <= 1'b1;
                  if (terminal_d) begin
                    done_q <= 1'b1;
                    if (auto_reload_i) begin
                      count_q <= reload_q;
                    end else begin
                      count_q <= '0;
                      state_q <= IDLE;
                      busy_q  <= 1'b0;
                    end
                  end else begin
                    count_q <= count_dec_d;
                  end
                end
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_o = count_q;
  assign busy_o  = busy_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a randomized run,
// compared against an elapsed-time reference model.
module tb_countdown_timer;

  localparam int W = 4;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         pause = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         busy, tick, done;

  int tests = 0;
  int failed = 0;

  // Reference model: elapsed active cycles since the interval began.
  bit m_active = 1'b0;
  int m_n = 0;
  int m_e = 0;
  int m_count = 0;
  bit m_busy = 1'b0, m_tick = 1'b0, m_done = 1'b0;

  countdown_timer #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .start_i(start), .load_val_i(load_val),
    .pause_i(pause), .auto_reload_i(auto_reload),
    .count_o(count), .busy_o(busy), .tick_o(tick), .done_o(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_edge(input bit s, input int lv, input bit p, input bit ar, input bit r);
    m_tick = 1'b0;
    m_done = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_e = 0;
    end else if (s) begin
      if (lv != 0) begin
        m_active = 1'b1;
        m_n = lv;
        m_e = 0;
      end else begin
        m_active = 1'b0;
        m_done = 1'b1;
      end
    end else if (m_active && !p) begin
      m_e = m_e + 1;
      if (m_e % P == 0) m_tick = 1'b1;
      if (m_e == m_n * P) begin
        m_done = 1'b1;
        if (ar) m_e = 0;
        else m_active = 1'b0;
      end
    end
    m_busy = m_active;
    m_count = m_active ? (m_n - m_e / P) : 0;
  endtask

  task automatic cycle(input bit s, input int lv, input bit p, input bit ar, input bit r);
    @(negedge clk);
    start = s;
    load_val = W'(lv);
    pause = p;
    auto_reload = ar;
    rst = r;
    @(posedge clk);
    model_edge(s, lv, p, ar, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 5, 1'b0, 1'b0, 1'b1);
      tests++;
      if ({count, busy, tick, done} !== 7'b0) begin
        failed++;
        $display("FAIL reset[%0d]: got count=%0d busy=%b tick=%b done=%b, want all 0", i, count, busy, tick, done);
      end
    end
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    int  exp_cnt[7] = '{3, 3, 2, 2, 1, 1, 0};
    bit  exp_tick[7] = '{0, 0, 1, 0, 1, 0, 1};
    bit  exp_done[7] = '{0, 0, 0, 0, 0, 0, 1};
    bit  exp_busy[7] = '{1, 1, 1, 1, 1, 1, 0};
    for (int e = 0; e < 7; e++) begin
      cycle(e == 0, 3, 1'b0, 1'b0, 1'b0);
      tests++;
      if (count !== W'(exp_cnt[e]) || tick !== exp_tick[e] || done !== exp_done[e] || busy !== exp_busy[e]) begin
        failed++;
        $display("FAIL basic edge %0d: got c=%0d b=%b t=%b d=%b, want c=%0d b=%b t=%b d=%b",
                 e, count, busy, tick, done, exp_cnt[e], exp_busy[e], exp_tick[e], exp_done[e]);
      end
    end
  endtask

  task automatic test_zero_load();
    cycle(1'b1, 0, 1'b0, 1'b0, 1'b0);
    tests++;
    if ({count, busy, tick, done} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      failed++;
      $display("FAIL zero_load: got c=%0d b=%b t=%b d=%b, want c=0 b=0 t=0 d=1", count, busy, tick, done);
    end
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL zero_load_after: got b=%b d=%b, want b=0 d=0", busy, done);
    end
  endtask

  task automatic test_pause();
    for (int e = 0; e <= 13; e++) begin
      cycle(e == 0, 4, (e >= 3 && e <= 5), 1'b0, 1'b0);
      tests++;
      if (done !== (e == 11) || busy !== (e < 11) || (e >= 2 && e <= 6 && count !== 4'd3)) begin
        failed++;
        $display("FAIL pause edge %0d: got c=%0d b=%b d=%b", e, count, busy, done);
      end
      tests++;
      if ({count, busy, tick, done} !== {W'(m_count), m_busy, m_tick, m_done}) begin
        failed++;
        $display("FAIL pause_model edge %0d: got c=%0d b=%b t=%b d=%b, want c=%0d b=%b t=%b d=%b",
                 e, count, busy, tick, done, m_count, m_busy, m_tick, m_done);
      end
    end
  endtask

  task automatic test_auto_reload();
    int exp_cnt[10] = '{2, 2, 1, 1, 2, 2, 1, 1, 0, 0};
    for (int e = 0; e <= 9; e++) begin
      cycle(e == 0, 2, 1'b0, (e <= 5), 1'b0);
      tests++;
      if (count !== W'(exp_cnt[e]) || done !== (e == 4 || e == 8) || busy !== (e < 8)) begin
        failed++;
        $display("FAIL auto_reload edge %0d: got c=%0d b=%b d=%b, want c=%0d", e, count, busy, done, exp_cnt[e]);
      end
    end
  endtask

  task automatic test_restart_reset();
    int guard;
    bit seen_done = 1'b0;
    cycle(1'b1, 9, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (count !== 4'd5 && guard < 40) begin
      cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
      if (done) seen_done = 1'b1;
      guard++;
    end
    tests++;
    if (guard >= 40) begin
      failed++;
      $display("FAIL restart_wait5: got count=%0d, want 5 within 40 cycles", count);
    end
    cycle(1'b1, 6, 1'b0, 1'b0, 1'b0);
    tests++;
    if (count !== 4'd6 || busy !== 1'b1 || done !== 1'b0) begin
      failed++;
      $display("FAIL restart_load: got c=%0d b=%b d=%b, want c=6 b=1 d=0", count, busy, done);
    end
    // A restarted prescaler needs a full P cycles before the next decrement.
    for (int i = 1; i < P; i++) begin
      cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
      if (done) seen_done = 1'b1;
    end
    tests++;
    if (count !== 4'd6) begin
      failed++;
      $display("FAIL restart_psc: got c=%0d, want 6", count);
    end
    guard = 0;
    while (count !== 4'd3 && guard < 40) begin
      cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
      if (done) seen_done = 1'b1;
      guard++;
    end
    tests++;
    if (guard >= 40 || seen_done) begin
      failed++;
      $display("FAIL restart_run: got count=%0d done_seen=%b, want count=3 done_seen=0", count, seen_done);
    end
    cycle(1'b1, 7, 1'b0, 1'b0, 1'b1);
    tests++;
    if ({count, busy, tick, done} !== 7'b0) begin
      failed++;
      $display("FAIL midrun_reset: got c=%0d b=%b t=%b d=%b, want all 0", count, busy, tick, done);
    end
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3, 1'b0, 1'b0, 1'b0);
    tests++;
    if (count !== 4'd3 || busy !== 1'b1 || done !== 1'b0 || tick !== 1'b0) begin
      failed++;
      $display("FAIL back_to_back: got c=%0d b=%b t=%b d=%b, want c=3 b=1 t=0 d=0", count, busy, tick, done);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      bit s, p, ar, r;
      int lv;
      s  = ($urandom_range(0, 19) == 0);
      lv = $urandom_range(0, 15);
      p  = ($urandom_range(0, 5) == 0);
      ar = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 99) == 0);
      cycle(s, lv, p, ar, r);
      tests++;
      if ({count, busy, tick, done} !== {W'(m_count), m_busy, m_tick, m_done}) begin
        failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cycle %0d: got c=%0d b=%b t=%b d=%b, want c=%0d b=%b t=%b d=%b",
                   i, count, busy, tick, done, m_count, m_busy, m_tick, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_load();
    test_pause();
    test_auto_reload();
    test_restart_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
